// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: sends a sync word, PAYLOAD_BYTES bytes (MSB first)
// taken over a valid/ready byte interface, then GUARD_LEN zero guard bits.
module sync_frame_tx #(
  parameter logic [7:0] SYNC_WORD     = 8'hB1,
  parameter int         PAYLOAD_BYTES = 4,
  parameter int         GUARD_LEN     = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx_bit,
  output logic       tx_valid,
  output logic       busy,
  output logic       done,
  output logic [3:0] frame_count,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SYNC    = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_STALL   = 3'd3;
  localparam logic [2:0] S_GUARD   = 3'd4;

  localparam logic [3:0] LAST_BYTE  = 4'(PAYLOAD_BYTES);
  localparam logic [3:0] LAST_GUARD = 4'(GUARD_LEN - 1);

  logic [2:0] state;
  logic [2:0] bit_idx;
  logic [3:0] byte_cnt;
  logic [3:0] guard_cnt;
  logic [7:0] shreg;
  logic       accept;

  // Byte handshake: a byte moves when data_valid && data_ready at a rising
  // edge. data_ready depends only on state, never on data_valid.
  always_comb begin
    data_ready = 1'b0;
    case (state)
      S_SYNC:    data_ready = (bit_idx == 3'd7);
      S_PAYLOAD: data_ready = (bit_idx == 3'd7) && (byte_cnt < LAST_BYTE);
      S_STALL:   data_ready = 1'b1;
      default:   data_ready = 1'b0;
    endcase
  end

  assign accept = data_ready && data_valid;

  always_comb begin
    tx_valid = 1'b0;
    tx_bit   = 1'b0;
    case (state)
      S_SYNC: begin
        tx_valid = 1'b1;
        tx_bit   = SYNC_WORD[~bit_idx];
      end
      S_PAYLOAD: begin
        tx_valid = 1'b1;
        tx_bit   = shreg[7];
      end
      S_GUARD:  tx_valid = 1'b1;
      default: begin
        tx_valid = 1'b0;
        tx_bit   = 1'b0;
      end
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      bit_idx     <= 3'd0;
      byte_cnt    <= 4'd0;
      guard_cnt   <= 4'd0;
      shreg       <= 8'd0;
      done        <= 1'b0;
      frame_count <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_SYNC;
            bit_idx  <= 3'd0;
            byte_cnt <= 4'd0;
          end
        end
        S_SYNC, S_PAYLOAD: begin
          bit_idx <= bit_idx + 3'd1;
          shreg   <= {shreg[6:0], 1'b0};
          if (bit_idx == 3'd7) begin
            if (accept) begin
              state    <= S_PAYLOAD;
              shreg    <= data_in;
              byte_cnt <= byte_cnt + 4'd1;
            end else if (data_ready) begin
              state <= S_STALL;
            end else begin
              state     <= S_GUARD;
              guard_cnt <= 4'd0;
            end
          end
        end
        S_STALL: begin
          if (accept) begin
            state    <= S_PAYLOAD;
            shreg    <= data_in;
            bit_idx  <= 3'd0;
            byte_cnt <= byte_cnt + 4'd1;
          end
        end
        S_GUARD: begin
          guard_cnt <= guard_cnt + 4'd1;
          // done and the frame count update land in the first IDLE cycle
          if (guard_cnt == LAST_GUARD) begin
            state       <= S_IDLE;
            done        <= 1'b1;
            frame_count <= frame_count + 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_frame_tx.sv
// Directed bench for sync_frame_tx: default/stall/abort/busy-start frames,
// back-to-back frames, and a 1-byte / 1-guard-bit variant.
module tb_sync_frame_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready, tx_bit, tx_valid, busy, done;
  logic [3:0] frame_count;
  logic [2:0] state_dbg;

  logic       s2_start;
  logic [7:0] s2_data_in;
  logic       s2_data_valid;
  logic       s2_data_ready, s2_tx_bit, s2_tx_valid, s2_busy, s2_done;
  logic [3:0] s2_frame_count;
  logic [2:0] s2_state_dbg;

  int vectors     = 0;
  int miscompares = 0;
  int exp_fc      = 0;

  logic [0:0] exp_q[$];
  logic [7:0] frame_bytes[4] = '{8'h12, 8'h34, 8'h56, 8'h78};

  always #5 clk = ~clk;

  sync_frame_tx dut (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in),
    .data_valid(data_valid), .data_ready(data_ready), .tx_bit(tx_bit),
    .tx_valid(tx_valid), .busy(busy), .done(done),
    .frame_count(frame_count), .state_dbg(state_dbg)
  );

  sync_frame_tx #(.PAYLOAD_BYTES(1), .GUARD_LEN(1)) dut2 (
    .clk(clk), .reset(reset), .start(s2_start), .data_in(s2_data_in),
    .data_valid(s2_data_valid), .data_ready(s2_data_ready), .tx_bit(s2_tx_bit),
    .tx_valid(s2_tx_valid), .busy(s2_busy), .done(s2_done),
    .frame_count(s2_frame_count), .state_dbg(s2_state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx_bit"}, 32'(tx_bit), 0);
    check({tag, "_tx_valid"}, 32'(tx_valid), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_data_ready"}, 32'(data_ready), 0);
    check({tag, "_frame_count"}, 32'(frame_count), 0);
    check({tag, "_state"}, 32'(state_dbg), 0);
  endtask

  // One frame on dut. stall_len: cycles data_valid is withheld at the second
  // byte boundary. poke_start: extra start pulses in SYNC and GUARD.
  // abort_at: nonzero returns at that cycle so the caller can assert reset.
  task automatic run_frame(input int stall_len, input bit poke_start, input int abort_at);
    int idx = 0, stall_left = stall_len, valid_cnt = 0, stall_cnt = 0;
    int done_at = -1, done_cnt = 0;
    exp_q.delete();
    for (int b = 7; b >= 0; b--) exp_q.push_back(1'(8'hB1 >> b));
    for (int k = 0; k < 4; k++)
      for (int b = 7; b >= 0; b--) exp_q.push_back(1'(frame_bytes[k] >> b));
    for (int g = 0; g < 7; g++) exp_q.push_back(1'b0);

    @(negedge clk);
    start = 1'b1; data_valid = 1'b1; data_in = frame_bytes[0];
    @(posedge clk);
    for (int c = 1; c <= 150; c++) begin
      @(negedge clk);
      if (c == abort_at) begin
        check("abort_no_done", 32'(done_cnt), 0);
        return;
      end
      start = poke_start && (c == 3 || c == 43);
      if (tx_valid) begin
        if (valid_cnt == 0) check("first_bit_cycle", 32'(c), 1);
        valid_cnt++;
        if (exp_q.size() == 0) check("extra_bit", 32'(tx_bit), 32'hFFFF_FFFF);
        else check("bit", 32'(tx_bit), 32'(exp_q.pop_front()));
      end else if (busy) begin
        stall_cnt++;
        check("stall_bit", 32'(tx_bit), 0);
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (done_at >= 0 && c == done_at + 1) check("idle_after_done", 32'(busy), 0);
      if (data_ready && stall_left > 0 && idx == 1) begin
        data_valid = 1'b0;
        stall_left--;
      end else begin
        data_valid = 1'b1;
      end
      data_in = (idx < 4) ? frame_bytes[idx] : 8'h00;
      if (data_ready && data_valid) idx++;
      if (done_at >= 0 && c >= done_at + 2) break;
    end
    exp_fc = (exp_fc + 1) % 16;
    check("valid_cycles", 32'(valid_cnt), 47);
    check("bits_left", 32'(exp_q.size()), 0);
    check("stall_cycles", 32'(stall_cnt), 32'(stall_len));
    check("done_cycle", 32'(done_at), 32'(48 + stall_len));
    check("done_pulses", 32'(done_cnt), 1);
    check("frame_count", 32'(frame_count), 32'(exp_fc));
  endtask

  task automatic run_back_to_back();
    int k = 0, prev = -1;
    @(negedge clk);
    start = 1'b1; data_valid = 1'b1; data_in = 8'hA5;
    for (int c = 1; c <= 16 * 48 + 40; c++) begin
      @(negedge clk);
      if (done) begin
        k++;
        check("b2b_fc", 32'(frame_count), 32'(k % 16));
        check("b2b_idle", 32'(busy), 0);
        if (prev >= 0) check("b2b_period", 32'(c - prev), 48);
        prev = c;
        if (k == 16) begin
          start = 1'b0;
          break;
        end
      end
    end
    check("b2b_frames", 32'(k), 16);
    @(negedge clk);
    check("b2b_stop", 32'(busy), 0);
  endtask

  task automatic run_short_frame();
    int valid_cnt = 0, done_at = -1;
    exp_q.delete();
    for (int b = 7; b >= 0; b--) exp_q.push_back(1'(8'hB1 >> b));
    for (int b = 0; b < 8; b++) exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    @(negedge clk);
    s2_start = 1'b1; s2_data_valid = 1'b1; s2_data_in = 8'hFF;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      s2_start = 1'b0;
      if (s2_tx_valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) check("s2_extra_bit", 32'(s2_tx_bit), 32'hFFFF_FFFF);
        else check("s2_bit", 32'(s2_tx_bit), 32'(exp_q.pop_front()));
      end
      if (s2_done && done_at < 0) done_at = c;
      if (done_at >= 0 && c >= done_at + 1) break;
    end
    check("s2_valid_cycles", 32'(valid_cnt), 17);
    check("s2_done_cycle", 32'(done_at), 18);
    check("s2_frame_count", 32'(s2_frame_count), 1);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; data_in = 8'h00; data_valid = 1'b0;
    s2_start = 1'b0; s2_data_in = 8'h00; s2_data_valid = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    run_frame(0, 1'b0, 0);
    run_frame(3, 1'b0, 0);

    run_frame(0, 1'b0, 20);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (3) begin
      @(negedge clk);
      check("abort_hold_done", 32'(done), 0);
    end
    reset = 1'b1;
    exp_fc = 0;
    @(negedge clk);
    check("abort_fc", 32'(frame_count), 0);
    check("abort_idle", 32'(busy), 0);
    run_frame(0, 1'b0, 0);

    run_frame(0, 1'b1, 0);

    @(negedge clk);
    reset = 1'b0;
    #1;
    reset = 1'b1;
    run_back_to_back();

    run_short_frame();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
